// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_reg_chain_if : valid/ready/data handshake bundle for pipe_reg_chain
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pipe_reg_chain_if #(
    parameter int WIDTH = 15
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_reg_chain : DEPTH-stage valid/ready register pipeline with bubble
//                  collapsing, synchronous flush and registered occupancy.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
    parameter int               WIDTH     = 15,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       flush,
    pipe_reg_chain_if.slave                 up,
    pipe_reg_chain_if.master                dn,
    output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];

    // A stage may load if downstream accepts or any stage at/after it is empty;
    // closed form of the ready chain, avoids a bit-wise self-dependent vector.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
            assign rdy[k] = dn.ready | ~(&v[DEPTH-1:k]);
        end
    endgenerate

    assign up.ready = rdy[0] & ~flush;
    assign dn.valid = v[DEPTH-1] & ~flush;
    assign dn.data  = d[DEPTH-1];

    always_comb begin
        v_nxt = v;
        if (flush) begin
            v_nxt = '0;
        end else begin
            if (rdy[0]) v_nxt[0] = up.valid;
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) v_nxt[k] = v[k-1];
            end
        end
    end

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] bits);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + OCC_W'(bits[i]);
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= popcount(v_nxt);
        end
    end

    // Data registers only capture real words, so bubbles never disturb them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
        end else if (!flush) begin
            if (rdy[0] && up.valid) d[0] <= up.data;
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k] && v[k-1]) d[k] <= d[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_reg_chain : scoreboard bench for pipe_reg_chain at DEPTH 1, 3 and 5
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '1;
    logic [14:0] idat [3];
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [14:0] od [3];
    logic [0:0]  occ_d1;
    logic [1:0]  occ_d3;
    logic [2:0]  occ_d5;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    typedef struct packed {
        logic [1:0]  tag;
        logic [14:0] data;
        logic [31:0] edge_no;
    } sb_t;
    sb_t sb [$];

    logic [2:0]  stall_prev = '0;
    logic [14:0] prev_od [3];

    pipe_reg_chain_if #(.WIDTH(15)) up0 ();
    pipe_reg_chain_if #(.WIDTH(15)) dn0 ();
    pipe_reg_chain_if #(.WIDTH(15)) up1 ();
    pipe_reg_chain_if #(.WIDTH(15)) dn1 ();
    pipe_reg_chain_if #(.WIDTH(15)) up2 ();
    pipe_reg_chain_if #(.WIDTH(15)) dn2 ();

    assign up0.valid = iv[0];  assign up0.data = idat[0];  assign dn0.ready = ordy[0];
    assign up1.valid = iv[1];  assign up1.data = idat[1];  assign dn1.ready = ordy[1];
    assign up2.valid = iv[2];  assign up2.data = idat[2];  assign dn2.ready = ordy[2];
    assign ir = {up2.ready, up1.ready, up0.ready};
    assign ov = {dn2.valid, dn1.valid, dn0.valid};
    assign od[0] = dn0.data;
    assign od[1] = dn1.data;
    assign od[2] = dn2.data;

    pipe_reg_chain #(.WIDTH(15), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush), .up(up0.slave), .dn(dn0.master), .occupancy(occ_d1));
    pipe_reg_chain #(.WIDTH(15), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush), .up(up1.slave), .dn(dn1.master), .occupancy(occ_d3));
    pipe_reg_chain #(.WIDTH(15), .DEPTH(5)) u_d5 (
        .clk(clk), .reset(reset), .flush(flush), .up(up2.slave), .dn(dn2.master), .occupancy(occ_d5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int count_tag(input int j);
        int n;
        n = 0;
        for (int k = 0; k < sb.size(); k++) if (sb[k].tag == 2'(j)) n++;
        return n;
    endfunction

    // Scoreboard: transfers are judged mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (!reset || flush) begin
            sb.delete();
            stall_prev = '0;
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (stall_prev[j]) begin
                    check_cnt++;
                    if (ov[j] !== 1'b1 || od[j] !== prev_od[j]) begin
                        $display("FAIL stall_stable[%0d]: got valid=%b data=%h, required valid=1 data=%h",
                                 j, ov[j], od[j], prev_od[j]);
                    end else pass_cnt++;
                end
                if (ov[j] && ordy[j]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].tag == 2'(j)) idx = k;
                    check_cnt++;
                    if (idx < 0) begin
                        $display("FAIL out_data[%0d]: got unexpected word %h, required no output", j, od[j]);
                    end else begin
                        if (od[j] !== sb[idx].data)
                            $display("FAIL out_data[%0d]: got %h, required %h", j, od[j], sb[idx].data);
                        else pass_cnt++;
                        sb.delete(idx);
                    end
                end
                if (iv[j] && ir[j]) sb.push_back('{tag: 2'(j), data: idat[j], edge_no: 32'(cyc + 1)});
                stall_prev[j] = ov[j] & ~ordy[j];
                prev_od[j]    = od[j];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int j, input int budget);
        int n;
        n = 0;
        while (count_tag(j) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_cnt++;
        if (count_tag(j) != 0)
            $display("FAIL drain[%0d]: got %0d words left, required 0", j, count_tag(j));
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        check_cnt++;
        if (ov !== 3'b000 || od[1] !== 15'h0000 || occ_d3 !== 2'd0)
            $display("FAIL reset_state: got valid=%b data=%h occ=%0d, required valid=000 data=0000 occ=0",
                     ov, od[1], occ_d3);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (ir !== 3'b111)
            $display("FAIL reset_ready: got in_ready=%b, required 111", ir);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ordy = '1;
        for (int c = 0; c < 14; c++) begin
            tick();
            iv[1]   = (c < 10);
            idat[1] = 15'(c + 1);
            @(negedge clk);
            check_cnt++;
            if (ov[1] !== ((c >= 3) && (c < 13)))
                $display("FAIL b2b_valid c=%0d: got %b, required %b", c, ov[1], (c >= 3) && (c < 13));
            else pass_cnt++;
            if (c >= 3 && c < 13) begin
                check_cnt++;
                if (od[1] !== 15'(c - 2))
                    $display("FAIL b2b_data c=%0d: got %h, required %h", c, od[1], 15'(c - 2));
                else pass_cnt++;
            end
        end
        tick();
        iv[1] = 1'b0;
        drain(1, 10);
    endtask

    task automatic test_backpressure();
        int w;
        w = 0;
        tick();
        ordy[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            iv[1]   = 1'b1;
            idat[1] = 15'(15'h0011 + w);
            @(negedge clk);
            if (ir[1]) w++;
        end
        check_cnt++;
        if (w != 3 || ir[1] !== 1'b0 || occ_d3 !== 2'd3 || ov[1] !== 1'b1 || od[1] !== 15'h0011)
            $display("FAIL full_state: got acc=%0d rdy=%b occ=%0d valid=%b data=%h, required 3 0 3 1 0011",
                     w, ir[1], occ_d3, ov[1], od[1]);
        else pass_cnt++;
        tick();
        ordy[1] = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (ir[1] !== 1'b1)
            $display("FAIL full_passthru: got in_ready=%b, required 1", ir[1]);
        else pass_cnt++;
        tick();
        iv[1] = 1'b0;
        drain(1, 12);
    endtask

    task automatic test_bubble_collapse();
        tick();
        ordy[1] = 1'b0;
        iv[1] = 1'b1; idat[1] = 15'h7FFF;
        tick();
        iv[1] = 1'b0;
        tick();
        tick();
        iv[1] = 1'b1; idat[1] = 15'h4000;
        tick();
        iv[1] = 1'b0;
        tick();
        @(negedge clk);
        check_cnt++;
        if (occ_d3 !== 2'd2 || ov[1] !== 1'b1 || od[1] !== 15'h7FFF || ir[1] !== 1'b1)
            $display("FAIL collapse: got occ=%0d valid=%b data=%h rdy=%b, required 2 1 7fff 1",
                     occ_d3, ov[1], od[1], ir[1]);
        else pass_cnt++;
        tick();
        ordy[1] = 1'b1;
        drain(1, 10);
    endtask

    task automatic test_flush();
        tick();
        ordy[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv[1] = 1'b1; idat[1] = 15'(15'h0021 + c);
            tick();
        end
        iv[1] = 1'b0;
        tick();
        flush = 1'b1; iv[1] = 1'b1; idat[1] = 15'h0BAD; ordy[1] = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (ir[1] !== 1'b0 || ov[1] !== 1'b0 || occ_d3 !== 2'd3)
            $display("FAIL flush_block: got rdy=%b valid=%b occ=%0d, required 0 0 3", ir[1], ov[1], occ_d3);
        else pass_cnt++;
        tick();
        flush = 1'b0; iv[1] = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (occ_d3 !== 2'd0 || ov[1] !== 1'b0 || ir[1] !== 1'b1)
            $display("FAIL flush_clear: got occ=%0d valid=%b rdy=%b, required 0 0 1", occ_d3, ov[1], ir[1]);
        else pass_cnt++;
        repeat (8) @(negedge clk);
        check_cnt++;
        if (ov[1] !== 1'b0)
            $display("FAIL flush_ghost: got valid=%b, required 0", ov[1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        tick();
        ordy[1] = 1'b1;
        iv[1] = 1'b1; idat[1] = 15'h0031;
        tick();
        idat[1] = 15'h0032;
        tick();
        iv[1] = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_cnt++;
        if (ov[1] !== 1'b0 || od[1] !== 15'h0000 || occ_d3 !== 2'd0)
            $display("FAIL reset_async: got valid=%b data=%h occ=%0d, required 0 0000 0", ov[1], od[1], occ_d3);
        else pass_cnt++;
        @(negedge clk);
        #2 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            iv[1] = (c == 0);
            idat[1] = 15'h0123;
            @(negedge clk);
            check_cnt++;
            if (ov[1] !== (c == 3) || (c == 3 && od[1] !== 15'h0123))
                $display("FAIL reset_resume c=%0d: got valid=%b data=%h, required valid=%b data=0123",
                         c, ov[1], od[1], c == 3);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int acc [3];
        int n;
        bit done;
        acc = '{0, 0, 0};
        n = 0;
        done = 1'b0;
        while (!done && n < 30000) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                iv[j]   = (acc[j] < 1000) ? 1'($urandom_range(1)) : 1'b0;
                idat[j] = 15'($urandom);
                ordy[j] = 1'($urandom_range(1));
            end
            @(negedge clk);
            for (int j = 0; j < 3; j++) if (iv[j] && ir[j]) acc[j]++;
            done = (acc[0] == 1000) && (acc[1] == 1000) && (acc[2] == 1000) && (sb.size() == 0);
            n++;
        end
        for (int j = 0; j < 3; j++) begin
            check_cnt++;
            if (acc[j] != 1000 || count_tag(j) != 0)
                $display("FAIL random[%0d]: got accepted=%0d pending=%0d, required 1000 0",
                         j, acc[j], count_tag(j));
            else pass_cnt++;
        end
        tick();
        iv = '0;
        ordy = '1;
    endtask

    initial begin
        idat[0] = '0; idat[1] = '0; idat[2] = '0;
        prev_od[0] = '0; prev_od[1] = '0; prev_od[2] = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
